ntt_bitrev_loader: RTL and testbench
====================================

# ntt_bitrev_loader

Streaming input stage for the forward NTT butterfly networks. It accepts coefficients one per cycle over a valid/ready handshake and collects N of them per frame. Each frame is presented as one parallel vector in bit-reversed order, which is the order the `Butterfly_*point_network` `data_in` port expects. Two ping-pong banks let the producer fill frame k+1 while frame k waits for the consumer.

## Interface
- `WIDTH`, 8, coefficient width in bits (same as the butterfly `mod`/data width).
- `N`, 8, points per frame; a power of two, ≥ 2.
- `LOGN`, $clog2(N), derived; not to be overridden.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `mod`  in  WIDTH  modulus, only used when reduction is compiled in; held stable during a frame.
- `in_valid`  in  1  input sample valid.
- `in_ready`  out  1  stage can accept a sample.
- `in_data`  in  WIDTH  coefficient.
- `in_last`  in  1  marks the final sample of a frame.
- `out_valid`  out  1  a full bit-reversed frame is on `data_out`.
- `out_ready`  in  1  consumer takes the frame.
- `data_out`  out  WIDTH × [N-1:0] unpacked array, bit-reversed frame.
- `frame_err`  out  1  one-cycle pulse on a framing error.

## Operation
- Storage is two banks, B0 and B1, each N × WIDTH.
- Each bank has a state: EMPTY, FILLING or FULL.
- Pointers:
  - `wr_bank` and `rd_bank` are 1-bit bank selects.
  - `wr_idx` is the LOGN-bit sample counter.
- An input accept is `in_valid & in_ready`.
  - Sample number k (= `wr_idx`) is written to `bank[wr_bank][bitrev(k)]`, where bitrev reverses the LOGN bits.
  - The bank moves EMPTY→FILLING on the first accept.
  - `wr_idx` increments and wraps at N.
- Frame completion is an accept with k = N-1 and `in_last` = 1.
  - The bank becomes FULL, `wr_bank` toggles and `wr_idx` returns to 0.
- Framing errors:
  - `in_last` = 1 with k < N-1, or k = N-1 with `in_last` = 0.
  - On either error, `frame_err` pulses, the current bank returns to EMPTY and `wr_idx` returns to 0.
  - The offending sample is discarded.
- Output side:
  - `out_valid` = (`state[rd_bank]` == FULL).
  - `data_out[i]` = `bank[rd_bank][i]`, so `data_out[i]` holds sample bitrev(i).
  - An output handshake (`out_valid & out_ready`) sets `state[rd_bank]` to EMPTY and toggles `rd_bank`.
- `in_ready` = (`state[wr_bank]` != FULL). It is a decode of registered state only and has no combinational path from `out_ready`.
- Arithmetic: none apart from the optional reduction. Values are stored at WIDTH bits with no truncation or extension.

## Timing
- Reset values:
  - All bank words 0.
  - Both bank states EMPTY.
  - `wr_bank` = `rd_bank` = 0, `wr_idx` = 0.
  - `out_valid` = 0, `in_ready` = 1, `frame_err` = 0, `data_out` all 0.
- Latency:
  - `out_valid` rises in the cycle after the accept of sample N-1.
  - `frame_err` is asserted in the cycle after the offending accept, for exactly one cycle.
- Throughput: one sample per cycle, sustained, while the consumer pops within N cycles.
- Both banks FULL: `in_ready` = 0. After a pop, `in_ready` returns to 1 in the next cycle.
- `data_out` and `out_valid` are held stable while `out_valid` = 1 and `out_ready` = 0.
- Simultaneous frame completion on `wr_bank` and pop of `rd_bank` in the same cycle: both take effect.
- Reset mid-frame: the partial frame is lost and all state returns to reset values.

## Configuration
- Macro `NTT_BITREV_MODRED_EN`.
- Defined: each accepted sample is reduced before storage by a single conditional subtract: if `in_data` ≥ `mod`, store `in_data - mod`, otherwise store `in_data`. The result is correct for `in_data` < 2·`mod`.
- Undefined: `in_data` is stored verbatim and `mod` is unused.

## Test plan
- Normal frame: after reset, stream 0..7, `in_last` on 7, `out_ready` = 1 → `out_valid` the next cycle with `data_out` = 0,4,2,6,1,5,3,7, then a pop.
- Backpressure: `out_ready` = 0, stream 16 samples (0..15) → `in_ready` falls after sample 15. Raise `out_ready` → frame A = 0,4,2,6,1,5,3,7, then frame B = 8,12,10,14,9,13,11,15, and `in_ready` returns 1 cycle after the first pop.
- Early `in_last`: `in_last` on k = 5 → one-cycle `frame_err`, no `out_valid`. The next clean frame 0..7 is correct.
- Missing `in_last`: no `in_last` on k = 7 → `frame_err` pulse and the bank stays EMPTY.
- Reduction: `mod` = 29, input 30..37 → with the macro, 1,5,3,7,2,6,4,8; without it, 30,34,32,36,31,35,33,37.
- Reset mid-frame: assert `rst_n` = 0 after 4 samples → `out_valid` = 0, `in_ready` = 1. The following frame 0..7 is correct.

Source files
------------

// File: rtl/ntt_bitrev_loader_if.sv
// Handshake bundle for ntt_bitrev_loader: sample stream in, bit-reversed parallel frame out.
// The producer/consumer side uses the master modport; the loader uses the slave modport.
interface ntt_bitrev_loader_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_out [N-1:0];
  logic             frame_err;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  data_out,
    input  frame_err
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output data_out,
    output frame_err
  );
endinterface

// File: rtl/ntt_bitrev_loader.sv
// Ping-pong input stage collecting N streamed coefficients into a bit-reversed parallel frame.
// Define NTT_BITREV_MODRED_EN to conditionally subtract mod from each sample before storage.
module ntt_bitrev_loader #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 8,
  localparam int unsigned LOGN = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    mod,
  ntt_bitrev_loader_if.slave  bus
);

  typedef enum logic [1:0] {StEmpty, StFilling, StFull} bank_state_e;

  localparam logic [LOGN-1:0] LastIdx = LOGN'(N - 1);

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] k);
    logic [LOGN-1:0] r;
    for (int b = 0; b < int'(LOGN); b++) begin
      r[b] = k[int'(LOGN) - 1 - b];
    end
    return r;
  endfunction

  bank_state_e       bank_state_q [2];
  bank_state_e       bank_state_d [2];
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [LOGN-1:0]   wr_idx_q, wr_idx_d;
  logic              frame_err_q;
  logic [WIDTH-1:0]  mem_q [2][N];

  logic              in_ready;
  logic              out_valid;
  logic              accept;
  logic              at_last;
  logic              err;
  logic              complete;
  logic              pop;
  logic              wr_en;
  logic [WIDTH-1:0]  store_data;

  assign accept   = bus.in_valid & in_ready;
  assign at_last  = (wr_idx_q == LastIdx);
  // Either an early in_last or a missing in_last on the final slot is a framing error.
  assign err      = accept & (bus.in_last ^ at_last);
  assign complete = accept & at_last & bus.in_last;
  assign pop      = out_valid & bus.out_ready;
  assign wr_en    = accept & ~err;

`ifdef NTT_BITREV_MODRED_EN
  assign store_data = (bus.in_data >= mod) ? (bus.in_data - mod) : bus.in_data;
`else
  logic unused_mod;
  assign unused_mod = ^mod;
  assign store_data = bus.in_data;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_state_q[0] <= StEmpty;
      bank_state_q[1] <= StEmpty;
      wr_bank_q       <= 1'b0;
      rd_bank_q       <= 1'b0;
      wr_idx_q        <= '0;
      frame_err_q     <= 1'b0;
    end else begin
      bank_state_q <= bank_state_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      wr_idx_q     <= wr_idx_d;
      frame_err_q  <= err;
    end
  end

  // Next-state logic; a pop and a write never target the same bank because a FULL
  // write bank blocks in_ready.
  always_comb begin
    bank_state_d = bank_state_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    wr_idx_d     = wr_idx_q;

    if (pop) begin
      bank_state_d[rd_bank_q] = StEmpty;
      rd_bank_d               = ~rd_bank_q;
    end

    if (accept) begin
      if (err) begin
        bank_state_d[wr_bank_q] = StEmpty;
        wr_idx_d                = '0;
      end else if (complete) begin
        bank_state_d[wr_bank_q] = StFull;
        wr_bank_d               = ~wr_bank_q;
        wr_idx_d                = '0;
      end else begin
        bank_state_d[wr_bank_q] = StFilling;
        wr_idx_d                = wr_idx_q + 1'b1;
      end
    end
  end

  // Output decode from registered state only
  always_comb begin
    in_ready  = (bank_state_q[wr_bank_q] != StFull);
    out_valid = (bank_state_q[rd_bank_q] == StFull);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < int'(N); i++) begin
          mem_q[b][i] <= '0;
        end
      end
    end else if (wr_en) begin
      mem_q[wr_bank_q][bitrev(wr_idx_q)] <= store_data;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.frame_err = frame_err_q;

  for (genvar i = 0; i < int'(N); i++) begin : g_data_out
    assign bus.data_out[i] = mem_q[rd_bank_q][i];
  end

endmodule

// File: tb/tb_ntt_bitrev_loader.sv
// Scoreboard bench for ntt_bitrev_loader: stimulus queues expected frames, a monitor pops
// and compares them whenever the DUT presents a frame.
module tb_ntt_bitrev_loader;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned N     = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] mod;

  ntt_bitrev_loader_if #(.WIDTH(WIDTH), .N(N)) bus ();

  ntt_bitrev_loader #(.WIDTH(WIDTH), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mod   (mod),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned err_seen = 0;
  int unsigned err_exp  = 0;
  logic [63:0] exp_q [$];
  logic [63:0] mon_act;
  int unsigned brtab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] mk_frame(input int unsigned base);
    logic [63:0] f;
    for (int i = 0; i < 8; i++) f[i*8 +: 8] = 8'(base + brtab[i]);
    return f;
  endfunction

  function automatic logic [63:0] pack_out();
    logic [63:0] f;
    for (int i = 0; i < 8; i++) f[i*8 +: 8] = bus.data_out[i];
    return f;
  endfunction

  // Called #1 after a rising edge; returns #1 after the edge that accepted the sample.
  task automatic send(input logic [7:0] d, input logic last);
    int unsigned waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (!bus.in_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic stream(input int unsigned base, input int unsigned n, input int unsigned last_k);
    for (int unsigned k = 0; k < n; k++) send(8'(base + k), k == last_k);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Monitor: compare the presented frame every cycle it is valid, pop on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.frame_err) err_seen++;
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 64'd1, 64'd0);
        end else begin
          mon_act = pack_out();
          check("frame_data", mon_act, exp_q[0]);
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    mod           = 8'd29;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_frame_err", bus.frame_err, 0);
    check("rst_data_out", pack_out(), 0);
    rst_n = 1'b1;
    tick();

    // Normal frame
    bus.out_ready = 1'b1;
    exp_q.push_back(mk_frame(0));
    stream(0, 8, 7);
    check("latency_out_valid", bus.out_valid, 1);
    tick();
    check("pop_clears_valid", bus.out_valid, 0);

    // Backpressure: both banks fill, in_ready drops
    bus.out_ready = 1'b0;
    exp_q.push_back(mk_frame(0));
    exp_q.push_back(mk_frame(8));
    stream(0, 8, 7);
    check("bp_in_ready_mid", bus.in_ready, 1);
    stream(8, 8, 7);
    check("bp_in_ready_full", bus.in_ready, 0);
    check("bp_out_valid", bus.out_valid, 1);
    repeat (3) tick();
    check("bp_in_ready_hold", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    tick();
    check("bp_in_ready_after_pop", bus.in_ready, 1);
    check("bp_second_valid", bus.out_valid, 1);
    tick();
    check("bp_drained", bus.out_valid, 0);

    // Completion of one bank and pop of the other in the same cycle
    bus.out_ready = 1'b0;
    exp_q.push_back(mk_frame(16));
    exp_q.push_back(mk_frame(24));
    stream(16, 8, 7);
    stream(24, 7, 8);
    bus.out_ready = 1'b1;
    send(8'd31, 1'b1);
    check("simul_out_valid", bus.out_valid, 1);
    check("simul_in_ready", bus.in_ready, 1);
    tick();
    check("simul_drained", bus.out_valid, 0);

    // Early in_last
    stream(0, 6, 5);
    err_exp++;
    check("early_err_pulse", bus.frame_err, 1);
    check("early_no_valid", bus.out_valid, 0);
    tick();
    check("early_err_one_cycle", bus.frame_err, 0);
    exp_q.push_back(mk_frame(0));
    stream(0, 8, 7);
    tick();

    // Missing in_last
    stream(0, 8, 8);
    err_exp++;
    check("missing_err_pulse", bus.frame_err, 1);
    check("missing_no_valid", bus.out_valid, 0);
    tick();
    check("missing_err_one_cycle", bus.frame_err, 0);
    check("missing_bank_empty", bus.out_valid, 0);

    // Reduction
    mod = 8'd29;
`ifdef NTT_BITREV_MODRED_EN
    exp_q.push_back({8'd8, 8'd4, 8'd6, 8'd2, 8'd7, 8'd3, 8'd5, 8'd1});
`else
    exp_q.push_back({8'd37, 8'd33, 8'd35, 8'd31, 8'd36, 8'd32, 8'd34, 8'd30});
`endif
    stream(30, 8, 7);
    tick();

    // Reset mid-frame
    stream(0, 4, 8);
    rst_n = 1'b0;
    #2;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_data_out", pack_out(), 0);
    tick();
    rst_n = 1'b1;
    exp_q.push_back(mk_frame(0));
    stream(0, 8, 7);
    repeat (3) tick();

    check("queue_drained", 64'(exp_q.size()), 0);
    check("err_count", 64'(err_seen), 64'(err_exp));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
